// File: rtl/div_unit.sv
// Sequential restoring divider, signed or unsigned: N+1 edges from accept to result (1 edge for /0 and MIN/-1).
// Accepts only in IDLE; the result is held in DONE until res_ready_i, so the consumer can stall indefinitely.
module div_unit #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  input  logic         signed_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_by_zero_o
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [N-1:0]  MIN_VAL   = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dvs_q;
  logic          neg_quo;
  logic          neg_rem;

  logic          dividend_neg;
  logic          divisor_neg;
  logic [N-1:0]  dividend_mag;
  logic [N-1:0]  divisor_mag;
  logic [N:0]    diff;
  logic          step_ge;
  logic [N-1:0]  rem_next;
  logic [N-1:0]  quo_next;

  assign req_ready_o = (state == IDLE);
  assign res_valid_o = (state == DONE);

  always_comb begin
    dividend_neg = signed_i & dividend_i[N-1];
    divisor_neg  = signed_i & divisor_i[N-1];
    dividend_mag = dividend_neg ? -dividend_i : dividend_i;
    divisor_mag  = divisor_neg  ? -divisor_i  : divisor_i;
  end

  // quo_q starts as the dividend magnitude: its MSB feeds the partial remainder
  // while quotient bits shift in at the bottom. When the shifted remainder fits
  // in N bits, the top bit of the (N+1)-bit difference is its borrow.
  always_comb begin
    diff     = {rem_q, quo_q[N-1]} - {1'b0, dvs_q};
    step_ge  = rem_q[N-1] | ~diff[N];
    rem_next = step_ge ? diff[N-1:0] : {rem_q[N-2:0], quo_q[N-1]};
    quo_next = {quo_q[N-2:0], step_ge};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (divisor_i == '0) begin
              quotient_o    <= '1;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
              state         <= DONE;
            end else if (signed_i && dividend_i == MIN_VAL && divisor_i == '1) begin
              quotient_o    <= dividend_i;
              remainder_o   <= '0;
              div_by_zero_o <= 1'b0;
              state         <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= dividend_mag;
              dvs_q   <= divisor_mag;
              neg_quo <= dividend_neg ^ divisor_neg;
              neg_rem <= dividend_neg;
              cnt     <= '0;
              state   <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            // Negating a zero remainder yields zero, so no special case is needed.
            quotient_o    <= neg_quo ? -quo_next : quo_next;
            remainder_o   <= neg_rem ? -rem_next : rem_next;
            div_by_zero_o <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
